// File: rtl/uart_fpga_pkg.sv
// Shared UART definitions: receiver FSM encoding, line constants and the
// helpers that size the fractional tick accumulator.
package uart_fpga_pkg;

    localparam int DEFAULT_CLK_HZ = 100_000_000;
    localparam int DEFAULT_BAUD   = 115_200;
    localparam int DATA_BITS      = 8;
    localparam int OVERSAMPLING   = 16;
    localparam int TX_STOP_BITS   = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } rx_state_e;

    // Accumulator width: enough bits to cover the clock/tick ratio plus
    // eight fractional bits, which keeps the rate error far below 1 %.
    function automatic int acc_width(input longint clk_hz, input longint tick_hz);
        return $clog2(clk_hz / tick_hz) + 8;
    endfunction

    // Rounded phase increment added every clock.
    function automatic longint acc_increment(input longint clk_hz, input longint tick_hz,
                                             input int width);
        return ((tick_hz << width) + (clk_hz >> 1)) / clk_hz;
    endfunction

endpackage

// File: rtl/uart_fpga_geradorOversample.sv
// Fractional (accumulator-based) oversampling tick generator. The carry out of
// the phase accumulator is the tick, held for exactly one clock.
module uart_fpga_geradorOversample
    import uart_fpga_pkg::*;
#(
    parameter int ClkFrequency  = DEFAULT_CLK_HZ,
    parameter int TickFrequency = DEFAULT_BAUD * OVERSAMPLING
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int     AccWidth = acc_width(longint'(ClkFrequency), longint'(TickFrequency));
    localparam longint IncFull  = acc_increment(longint'(ClkFrequency),
                                                longint'(TickFrequency), AccWidth);
    localparam logic [AccWidth:0] AccInc = IncFull[AccWidth:0];

    logic [AccWidth:0] acc_r;

    // Phase accumulator; clear restarts phase at zero, carry is dropped when disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r <= '0;
        end else if (clear) begin
            acc_r <= '0;
        end else if (enable) begin
            acc_r <= {1'b0, acc_r[AccWidth-1:0]} + AccInc;
        end else begin
            acc_r <= {1'b0, acc_r[AccWidth-1:0]};
        end
    end

    assign tick = acc_r[AccWidth];

endmodule

// File: rtl/uart_fpga_receptor.sv
// 8N1 UART receiver: synchroniser, oversampled start/data/stop sampling FSM,
// registered data, ready and frame-error pulses.
module uart_fpga_receptor
    import uart_fpga_pkg::*;
#(
    parameter int ClkFrequency = DEFAULT_CLK_HZ,
    parameter int Baud         = DEFAULT_BAUD,
    parameter int Oversampling = OVERSAMPLING
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RxD,
    output logic [DATA_BITS-1:0] RxD_data,
    output logic                 RxD_data_ready,
    output logic                 RxD_frame_error,
    output logic                 RxD_idle
);

    localparam int CntWidth    = $clog2(Oversampling);
    localparam int BitCntWidth = $clog2(DATA_BITS);
    localparam logic [CntWidth-1:0]    HalfCount = CntWidth'(Oversampling / 2 - 1);
    localparam logic [CntWidth-1:0]    FullCount = CntWidth'(Oversampling - 1);
    localparam logic [CntWidth-1:0]    CntOne    = CntWidth'(1);
    localparam logic [BitCntWidth-1:0] LastBit   = BitCntWidth'(DATA_BITS - 1);
    localparam logic [BitCntWidth-1:0] BitOne    = BitCntWidth'(1);

    rx_state_e                state_r, state_s;
    logic                     sync1_r, rxs_r;
    logic [CntWidth-1:0]      tick_cnt_r, tick_cnt_s;
    logic [BitCntWidth-1:0]   bit_cnt_r, bit_cnt_s;
    logic [DATA_BITS-1:0]     shift_r, shift_s;
    logic [DATA_BITS-1:0]     data_r, data_s;
    logic                     ready_r, ready_s;
    logic                     ferr_r, ferr_s;
    logic                     idle_r;
    logic                     tick_s, tg_enable_s, tg_clear_s;

    uart_fpga_geradorOversample #(
        .ClkFrequency (ClkFrequency),
        .TickFrequency(Baud * Oversampling)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .enable(tg_enable_s),
        .clear (tg_clear_s),
        .tick  (tick_s)
    );

    // Two-flop synchroniser for the asynchronous serial line; idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b1;
            rxs_r   <= 1'b1;
        end else begin
            sync1_r <= RxD;
            rxs_r   <= sync1_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state, counter, shift and output-pulse logic.
    always_comb begin
        state_s     = state_r;
        tick_cnt_s  = tick_cnt_r;
        bit_cnt_s   = bit_cnt_r;
        shift_s     = shift_r;
        data_s      = data_r;
        ready_s     = 1'b0;
        ferr_s      = 1'b0;
        tg_clear_s  = 1'b0;
        tg_enable_s = (state_r != ST_IDLE);
        case (state_r)
            ST_IDLE: begin
                if (!rxs_r) begin
                    state_s    = ST_START;
                    tg_clear_s = 1'b1;
                    tick_cnt_s = '0;
                    bit_cnt_s  = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s && (tick_cnt_r == HalfCount)) begin
                    tick_cnt_s = '0;
                    state_s    = rxs_r ? ST_IDLE : ST_DATA;
                end else if (tick_s) begin
                    tick_cnt_s = tick_cnt_r + CntOne;
                end else begin
                    tick_cnt_s = tick_cnt_r;
                end
            end
            ST_DATA: begin
                if (tick_s && (tick_cnt_r == FullCount)) begin
                    tick_cnt_s = '0;
                    shift_s    = {rxs_r, shift_r[DATA_BITS-1:1]};
                    bit_cnt_s  = bit_cnt_r + BitOne;
                    state_s    = (bit_cnt_r == LastBit) ? ST_STOP : ST_DATA;
                end else if (tick_s) begin
                    tick_cnt_s = tick_cnt_r + CntOne;
                end else begin
                    tick_cnt_s = tick_cnt_r;
                end
            end
            ST_STOP: begin
                if (tick_s && (tick_cnt_r == FullCount)) begin
                    tick_cnt_s = '0;
                    if (rxs_r) begin
                        data_s  = shift_r;
                        ready_s = 1'b1;
                        state_s = ST_IDLE;
                    end else begin
                        ferr_s  = 1'b1;
                        state_s = ST_WAIT_HIGH;
                    end
                end else if (tick_s) begin
                    tick_cnt_s = tick_cnt_r + CntOne;
                end else begin
                    tick_cnt_s = tick_cnt_r;
                end
            end
            ST_WAIT_HIGH: begin
                if (rxs_r) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT_HIGH;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Datapath registers and registered outputs; idle tracks next state/line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_r <= '0;
            bit_cnt_r  <= '0;
            shift_r    <= '0;
            data_r     <= '0;
            ready_r    <= 1'b0;
            ferr_r     <= 1'b0;
            idle_r     <= 1'b1;
        end else begin
            tick_cnt_r <= tick_cnt_s;
            bit_cnt_r  <= bit_cnt_s;
            shift_r    <= shift_s;
            data_r     <= data_s;
            ready_r    <= ready_s;
            ferr_r     <= ferr_s;
            idle_r     <= (state_s == ST_IDLE) && sync1_r;
        end
    end

    assign RxD_data        = data_r;
    assign RxD_data_ready  = ready_r;
    assign RxD_frame_error = ferr_r;
    assign RxD_idle        = idle_r;

endmodule

// File: tb/tb_uart_fpga_receptor.sv
// Directed self-checking bench for uart_fpga_receptor.
module tb_uart_fpga_receptor;
    import uart_fpga_pkg::*;

    // 16 clocks per bit, 8 ticks per bit, one tick every 2 clocks.
    localparam int  TbClkHz = 100_000_000;
    localparam int  TbBaud  = 6_250_000;
    localparam int  TbOs    = 8;
    localparam real BitT    = 1600.0;

    logic       clk = 1'b0;
    logic       rst;
    logic       RxD;
    logic [7:0] RxD_data;
    logic       RxD_data_ready;
    logic       RxD_frame_error;
    logic       RxD_idle;

    int checks   = 0;
    int failures = 0;
    int ready_cnt = 0;
    int ferr_cnt  = 0;
    int both_cnt  = 0;
    logic [7:0] rx_q[$];

    always #50 clk = ~clk;

    uart_fpga_receptor #(
        .ClkFrequency(TbClkHz),
        .Baud        (TbBaud),
        .Oversampling(TbOs)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .RxD            (RxD),
        .RxD_data       (RxD_data),
        .RxD_data_ready (RxD_data_ready),
        .RxD_frame_error(RxD_frame_error),
        .RxD_idle       (RxD_idle)
    );

    // Pulse monitor: counts every high cycle of ready / error and logs bytes.
    always @(negedge clk) begin
        if (RxD_data_ready) begin
            ready_cnt <= ready_cnt + 1;
            rx_q.push_back(RxD_data);
        end
        if (RxD_frame_error) ferr_cnt <= ferr_cnt + 1;
        if (RxD_data_ready && RxD_frame_error) both_cnt <= both_cnt + 1;
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rx_at(input int i);
        if (i < rx_q.size()) return {24'h0, rx_q[i]};
        else return 32'hFFFF_FFFF;
    endfunction

    // Line transmitter model: start, LSB-first data, stop bit(s).
    task automatic send_frame(input logic [7:0] b, input real bt, input int stop_bits);
        RxD = 1'b0;
        #(bt);
        for (int i = 0; i < DATA_BITS; i++) begin
            RxD = b[i];
            #(bt);
        end
        RxD = 1'b1;
        #(bt * stop_bits);
    endtask

    initial begin
        int base;
        int mism;
        rst = 1'b1;
        RxD = 1'b1;
        repeat (3) @(negedge clk);
        check_value("rst_data", {24'h0, RxD_data}, 32'h0);
        check_value("rst_ready", {31'h0, RxD_data_ready}, 32'h0);
        check_value("rst_ferr", {31'h0, RxD_frame_error}, 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_value("idle_after_rst", {31'h0, RxD_idle}, 32'h1);

        // Back-to-back 0x55, 0xA3 with one stop bit.
        send_frame(8'h55, BitT, 1);
        send_frame(8'hA3, BitT, 1);
        #(BitT * 2);
        check_value("b2b_count", ready_cnt, 32'd2);
        check_value("b2b_first", rx_at(0), 32'h55);
        check_value("b2b_second", rx_at(1), 32'hA3);
        check_value("b2b_no_err", ferr_cnt, 32'd0);
        check_value("b2b_data", {24'h0, RxD_data}, 32'hA3);

        // 0x00 with stop bit low for 3 bit times (12 bit times low total).
        RxD = 1'b0;
        #(BitT * 11);
        check_value("brk_one_err", ferr_cnt, 32'd1);
        check_value("brk_not_idle", {31'h0, RxD_idle}, 32'h0);
        check_value("brk_data_kept", {24'h0, RxD_data}, 32'hA3);
        #(BitT);
        RxD = 1'b1;
        #(BitT * 2);
        check_value("brk_idle_back", {31'h0, RxD_idle}, 32'h1);
        check_value("brk_err_total", ferr_cnt, 32'd1);
        check_value("brk_no_ready", ready_cnt, 32'd2);

        // 0.3-bit glitch on idle line, then 0x7E.
        RxD = 1'b0;
        #(BitT * 0.3);
        RxD = 1'b1;
        #(BitT * 2);
        check_value("glitch_no_ready", ready_cnt, 32'd2);
        check_value("glitch_no_err", ferr_cnt, 32'd1);
        check_value("glitch_idle", {31'h0, RxD_idle}, 32'h1);
        send_frame(8'h7E, BitT, 1);
        #(BitT);
        check_value("after_glitch_byte", rx_at(2), 32'h7E);
        check_value("after_glitch_count", ready_cnt, 32'd3);

        // Reset during bit 4 of 0xFF.
        RxD = 1'b0;
        #(BitT);
        for (int i = 0; i < 4; i++) begin
            RxD = 1'b1;
            #(BitT);
        end
        #(BitT * 0.5);
        rst = 1'b1;
        #1;
        check_value("midrst_data", {24'h0, RxD_data}, 32'h0);
        check_value("midrst_ready", {31'h0, RxD_data_ready}, 32'h0);
        check_value("midrst_ferr", {31'h0, RxD_frame_error}, 32'h0);
        #(BitT * 0.5 - 1.0);
        rst = 1'b0;
        #(BitT * 5);
        check_value("midrst_no_ready", ready_cnt, 32'd3);
        check_value("midrst_no_err", ferr_cnt, 32'd1);
        check_value("midrst_idle", {31'h0, RxD_idle}, 32'h1);
        send_frame(8'h12, BitT, 1);
        #(BitT);
        check_value("after_rst_byte", rx_at(3), 32'h12);
        check_value("after_rst_data", {24'h0, RxD_data}, 32'h12);

        // 0xC9 at -2 % and +2 % baud.
        send_frame(8'hC9, BitT * 1.02, 1);
        #(BitT);
        check_value("slow_c9", rx_at(4), 32'hC9);
        send_frame(8'hC9, BitT / 1.02, 1);
        #(BitT);
        check_value("fast_c9", rx_at(5), 32'hC9);
        check_value("drift_count", ready_cnt, 32'd6);

        // 256 sequential bytes, two stop bits.
        base = 6;
        for (int v = 0; v < 256; v++) begin
            send_frame(8'(v), BitT, TX_STOP_BITS);
        end
        #(BitT);
        mism = 0;
        for (int i = 0; i < 256; i++) begin
            if (rx_at(base + i) !== 32'(i)) mism++;
        end
        check_value("loop_order_mism", mism, 32'd0);
        check_value("loop_ready_total", ready_cnt, 32'd262);
        check_value("loop_err_total", ferr_cnt, 32'd1);
        check_value("never_both", both_cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
